// File: rtl/mux_scan_sequencer.sv
// Scan sequencer for an 8:1 single-bit mux.
// Steps sel 0..7, settles, samples, packs a byte for valid/ready.
module mux_scan_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       continuous,
  output logic [2:0] sel,
  input  logic       mux_in,
  output logic [7:0] data_out,
  output logic       valid,
  input  logic       ready,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SAMPLE,
    DONE
  } state_t;

  localparam logic [3:0] LAST = 4'(SETTLE_CYCLES - 1);

  state_t     state, state_n;
  logic [3:0] cnt, cnt_n;
  logic [7:0] cap, cap_n;
  logic [2:0] sel_n;
  logic [7:0] data_n;
  logic       valid_n;

  // State and all registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cap      <= '0;
      sel      <= '0;
      data_out <= '0;
      valid    <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      cap      <= cap_n;
      sel      <= sel_n;
      data_out <= data_n;
      valid    <= valid_n;
      busy     <= (state_n != IDLE);
    end
  end

  // Next-state and next-output logic; everything holds by default.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cap_n   = cap;
    sel_n   = sel;
    data_n  = data_out;
    valid_n = valid;
    unique case (state)
      IDLE: begin
        sel_n = '0;
        if (start) begin
          state_n = SETTLE;
          cnt_n   = '0;
          cap_n   = '0;
        end
      end
      SETTLE: begin
        cnt_n = cnt + 4'd1;
        if (cnt == LAST) state_n = SAMPLE;
      end
      SAMPLE: begin
        cap_n[sel] = mux_in;
        if (sel != 3'd7) begin
          sel_n   = sel + 3'd1;
          cnt_n   = '0;
          state_n = SETTLE;
        end else begin
          data_n  = {mux_in, cap[6:0]};
          valid_n = 1'b1;
          state_n = DONE;
        end
      end
      DONE: begin
        if (ready) begin
          valid_n = 1'b0;
          sel_n   = '0;
          cnt_n   = '0;
          state_n = continuous ? SETTLE : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: default and SETTLE_CYCLES=1 instances
// checked each cycle against a timeline model plus literal expectations.
module tb_mux_scan_sequencer;

  logic       clk = 1'b0;
  logic       rst_v[2];
  logic       start_v[2];
  logic       cont_v[2];
  logic       ready_v[2];
  logic       mux_v[2];
  logic [7:0] pat_v[2];
  logic [2:0] sel_o[2];
  logic [7:0] data_o[2];
  logic       valid_o[2];
  logic       busy_o[2];

  int nvec = 0;
  int nbad = 0;
  bit armed = 0;

  int sc[2] = '{2, 1};

  // Model state: scan timeline position rather than FSM states.
  bit         m_act[2]   = '{0, 0};
  int         m_t[2]     = '{0, 0};
  logic [7:0] m_cap[2]   = '{8'h00, 8'h00};
  logic [7:0] m_data[2]  = '{8'h00, 8'h00};
  bit         m_valid[2] = '{0, 0};
  logic [2:0] m_sel[2]   = '{3'd0, 3'd0};
  bit         m_busy[2]  = '{0, 0};
  int         per;

  always #5 clk = ~clk;

  assign mux_v[0] = pat_v[0][sel_o[0]];
  assign mux_v[1] = pat_v[1][sel_o[1]];

  mux_scan_sequencer dut0 (
    .clk       (clk),
    .rst       (rst_v[0]),
    .start     (start_v[0]),
    .continuous(cont_v[0]),
    .sel       (sel_o[0]),
    .mux_in    (mux_v[0]),
    .data_out  (data_o[0]),
    .valid     (valid_o[0]),
    .ready     (ready_v[0]),
    .busy      (busy_o[0])
  );

  mux_scan_sequencer #(.SETTLE_CYCLES(1)) dut1 (
    .clk       (clk),
    .rst       (rst_v[1]),
    .start     (start_v[1]),
    .continuous(cont_v[1]),
    .sel       (sel_o[1]),
    .mux_in    (mux_v[1]),
    .data_out  (data_o[1]),
    .valid     (valid_o[1]),
    .ready     (ready_v[1]),
    .busy      (busy_o[1])
  );

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Model: each channel takes per=S+1 cycles, sample on the last one.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      per = sc[i] + 1;
      if (rst_v[i]) begin
        m_act[i] = 0; m_t[i] = 0; m_cap[i] = 8'h00;
        m_data[i] = 8'h00; m_valid[i] = 0; m_sel[i] = 3'd0;
      end else if (m_valid[i]) begin
        if (ready_v[i]) begin
          m_valid[i] = 0;
          m_sel[i] = 3'd0;
          m_act[i] = cont_v[i];
          m_t[i] = 0;
        end
      end else if (m_act[i]) begin
        if (m_t[i] % per == per - 1)
          m_cap[i][m_t[i] / per] = pat_v[i][m_t[i] / per];
        m_t[i]++;
        if (m_t[i] == 8 * per) begin
          m_data[i] = m_cap[i];
          m_valid[i] = 1;
        end else begin
          m_sel[i] = 3'(m_t[i] / per);
        end
      end else if (start_v[i]) begin
        m_act[i] = 1;
        m_t[i] = 0;
        m_cap[i] = 8'h00;
      end
      m_busy[i] = m_act[i] || m_valid[i];
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (armed) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("u%0d sel", i), 32'(sel_o[i]), 32'(m_sel[i]));
        chk($sformatf("u%0d valid", i), 32'(valid_o[i]), 32'(m_valid[i]));
        chk($sformatf("u%0d data", i), 32'(data_o[i]), 32'(m_data[i]));
        chk($sformatf("u%0d busy", i), 32'(busy_o[i]), 32'(m_busy[i]));
      end
    end
  end

  // Waits for valid; n counts edges, the first edge counted being the
  // one right after the call (the start or handshake edge).
  task automatic wait_valid(input int i, input int rep, output int n);
    bit pulsed;
    pulsed = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      start_v[i] = (rep >= 0 && !pulsed && int'(sel_o[i]) == rep);
      if (start_v[i]) pulsed = 1;
    end while (valid_o[i] !== 1'b1 && n < 200);
    start_v[i] = 0;
    if (n >= 200) chk("valid timeout", 32'(n), 32'd0);
  endtask

  task automatic run_frame(input int i, input int rep, output int n);
    @(negedge clk);
    start_v[i] = 1;
    wait_valid(i, rep, n);
  endtask

  initial begin
    int n;
    int rises;
    for (int i = 0; i < 2; i++) begin
      rst_v[i] = 1; start_v[i] = 0; cont_v[i] = 0;
      ready_v[i] = 0; pat_v[i] = 8'h00;
    end
    @(negedge clk);
    @(negedge clk);
    rst_v[0] = 0;
    rst_v[1] = 0;
    armed = 1;
    chk("reset sel", 32'(sel_o[0]), 32'd0);
    chk("reset valid", 32'(valid_o[0]), 32'd0);
    chk("reset busy", 32'(busy_o[0]), 32'd0);
    chk("reset data", 32'(data_o[0]), 32'h00);

    // single shot
    pat_v[0] = 8'hA5;
    ready_v[0] = 1;
    run_frame(0, -1, n);
    chk("single latency", 32'(n), 32'd25);
    chk("single data", 32'(data_o[0]), 32'hA5);
    @(negedge clk);
    chk("single valid drop", 32'(valid_o[0]), 32'd0);
    chk("single idle busy", 32'(busy_o[0]), 32'd0);
    chk("single data kept", 32'(data_o[0]), 32'hA5);

    // backpressure
    ready_v[0] = 0;
    pat_v[0] = 8'h5A;
    run_frame(0, -1, n);
    chk("bp latency", 32'(n), 32'd25);
    for (int k = 0; k < 10; k++) begin
      chk("bp valid held", 32'(valid_o[0]), 32'd1);
      chk("bp data held", 32'(data_o[0]), 32'h5A);
      chk("bp sel held", 32'(sel_o[0]), 32'd7);
      @(negedge clk);
    end
    ready_v[0] = 1;
    @(negedge clk);
    chk("bp handshake", 32'(valid_o[0]), 32'd0);
    @(negedge clk);
    chk("bp single hs", 32'(valid_o[0]), 32'd0);

    // continuous
    cont_v[0] = 1;
    pat_v[0] = 8'h3C;
    run_frame(0, -1, n);
    chk("cont latency 1", 32'(n), 32'd25);
    chk("cont data 1", 32'(data_o[0]), 32'h3C);
    pat_v[0] = 8'hC3;
    wait_valid(0, -1, n);
    chk("cont latency 2", 32'(n), 32'd25);
    chk("cont data 2", 32'(data_o[0]), 32'hC3);
    chk("cont busy", 32'(busy_o[0]), 32'd1);
    cont_v[0] = 0;
    @(negedge clk);
    chk("cont stop busy", 32'(busy_o[0]), 32'd0);

    // reset mid-scan
    pat_v[0] = 8'h77;
    @(negedge clk);
    start_v[0] = 1;
    @(negedge clk);
    start_v[0] = 0;
    n = 0;
    while (sel_o[0] !== 3'd4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) chk("sel4 timeout", 32'(n), 32'd0);
    rst_v[0] = 1;
    @(negedge clk);
    rst_v[0] = 0;
    chk("rst sel", 32'(sel_o[0]), 32'd0);
    chk("rst valid", 32'(valid_o[0]), 32'd0);
    chk("rst busy", 32'(busy_o[0]), 32'd0);
    chk("rst data", 32'(data_o[0]), 32'h00);
    pat_v[0] = 8'hFF;
    run_frame(0, -1, n);
    chk("post rst latency", 32'(n), 32'd25);
    chk("post rst data", 32'(data_o[0]), 32'hFF);
    @(negedge clk);

    // start while busy
    pat_v[0] = 8'h96;
    run_frame(0, 2, n);
    chk("rebusy latency", 32'(n), 32'd25);
    chk("rebusy data", 32'(data_o[0]), 32'h96);
    rises = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (valid_o[0] === 1'b1) rises++;
    end
    chk("rebusy one frame", 32'(rises), 32'd0);
    chk("rebusy idle", 32'(busy_o[0]), 32'd0);

    // SETTLE_CYCLES=1 instance
    pat_v[1] = 8'h81;
    ready_v[1] = 1;
    run_frame(1, -1, n);
    chk("s1 latency", 32'(n), 32'd17);
    chk("s1 data", 32'(data_o[1]), 32'h81);
    @(negedge clk);
    chk("s1 idle", 32'(busy_o[1]), 32'd0);

    @(negedge clk);
    armed = 0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
